// File: rtl/pac_pkg.sv
// Shared definitions for the sprite motion block: headings, input codes,
// maze geometry, start position and the neighbour-tile lookup.
package pac_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOK_P = 3'd1,
        ST_CHK_P  = 3'd2,
        ST_LOOK_C = 3'd3,
        ST_CHK_C  = 3'd4,
        ST_STEP   = 3'd5
    } state_t;

    // Keypad codes
    localparam logic [4:0] KEY_LEFT  = 5'h0C;
    localparam logic [4:0] KEY_RIGHT = 5'h0E;
    localparam logic [4:0] KEY_UP    = 5'h09;
    localparam logic [4:0] KEY_DOWN  = 5'h11;

    // PS/2 set-2 scan codes (A/D/W/S) and the break prefix
    localparam logic [7:0] PS2_LEFT  = 8'h1C;
    localparam logic [7:0] PS2_RIGHT = 8'h23;
    localparam logic [7:0] PS2_UP    = 8'h1D;
    localparam logic [7:0] PS2_DOWN  = 8'h1B;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    // Geometry
    localparam int unsigned STEP  = 2;
    localparam int unsigned TILE  = 32;
    localparam int unsigned MAP_W = 20;
    localparam int unsigned MAP_H = 15;

    localparam logic [9:0] START_X = 10'd32;
    localparam logic [8:0] START_Y = 9'd32;

    typedef struct packed {
        logic       oob;
        logic [8:0] addr;
    } nbr_t;

    // Tile next to an aligned sprite in heading d; oob flags an off-map tile.
    function automatic nbr_t nbr_tile(input logic [9:0] x, input logic [8:0] y, input dir_t d);
        logic [4:0] col;
        logic [3:0] row;
        nbr_t       r;
        col    = x[9:5];
        row    = y[8:5];
        r.oob  = 1'b0;
        case (d)
            DIR_LEFT:  begin r.oob = (col == 5'd0);               col = col - 5'd1; end
            DIR_RIGHT: begin r.oob = (col == 5'(MAP_W - 1));      col = col + 5'd1; end
            DIR_UP:    begin r.oob = (row == 4'd0);               row = row - 4'd1; end
            default:   begin r.oob = (row == 4'(MAP_H - 1));      row = row + 4'd1; end
        endcase
        r.addr = {5'd0, row} * 9'(MAP_W) + {4'd0, col};
        return r;
    endfunction

endpackage

// File: rtl/pac_key_dec.sv
// Turns keypad / PS/2 level flags into one-clock direction events.
// Handles rising-edge detection, the PS/2 break-code skip, keypad priority
// and the code-to-heading mapping.
module pac_key_dec
    import pac_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] key_code,
    input  logic       key_ready,
    input  logic [7:0] ps2_code,
    input  logic       ps2_ready,
    output logic       evt_valid,
    output logic [1:0] evt_dir
);

    logic key_ready_q, key_ready_d;
    logic ps2_ready_q, ps2_ready_d;
    logic skip_q, skip_d;
    logic key_evt, ps2_evt;
    logic k_hit, p_hit;
    dir_t k_dir, p_dir;

    // Edge history and skip flag; history resets high so a held key is not an event
    always_ff @(posedge clk) begin
        if (!rst) begin
            key_ready_q <= 1'b1;
            ps2_ready_q <= 1'b1;
            skip_q      <= 1'b0;
        end else begin
            key_ready_q <= key_ready_d;
            ps2_ready_q <= ps2_ready_d;
            skip_q      <= skip_d;
        end
    end

    // Edge detect, decode, break skip and keypad-over-PS/2 priority
    always_comb begin
        key_ready_d = key_ready;
        ps2_ready_d = ps2_ready;
        skip_d      = skip_q;
        key_evt     = key_ready & ~key_ready_q;
        ps2_evt     = ps2_ready & ~ps2_ready_q;
        k_hit       = 1'b0;
        k_dir       = DIR_LEFT;
        p_hit       = 1'b0;
        p_dir       = DIR_LEFT;

        if (key_evt) begin
            case (key_code)
                KEY_LEFT:  begin k_hit = 1'b1; k_dir = DIR_LEFT;  end
                KEY_RIGHT: begin k_hit = 1'b1; k_dir = DIR_RIGHT; end
                KEY_UP:    begin k_hit = 1'b1; k_dir = DIR_UP;    end
                KEY_DOWN:  begin k_hit = 1'b1; k_dir = DIR_DOWN;  end
                default:   ;
            endcase
        end

        // The event after a break prefix is the released key: drop it.
        if (ps2_evt) begin
            if (skip_q) begin
                skip_d = 1'b0;
            end else if (ps2_code == PS2_BREAK) begin
                skip_d = 1'b1;
            end else begin
                case (ps2_code)
                    PS2_LEFT:  begin p_hit = 1'b1; p_dir = DIR_LEFT;  end
                    PS2_RIGHT: begin p_hit = 1'b1; p_dir = DIR_RIGHT; end
                    PS2_UP:    begin p_hit = 1'b1; p_dir = DIR_UP;    end
                    PS2_DOWN:  begin p_hit = 1'b1; p_dir = DIR_DOWN;  end
                    default:   ;
                endcase
            end
        end

        evt_valid = k_hit | p_hit;
        evt_dir   = k_hit ? k_dir : p_dir;
    end

endmodule

// File: rtl/pac_motion.sv
// Sprite motion controller: latches requested headings and, on each frame
// tick, checks the maze ROM for walls before stepping the sprite 2 px.
module pac_motion
    import pac_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] key_code,
    input  logic       key_ready,
    input  logic [7:0] ps2_code,
    input  logic       ps2_ready,
    input  logic       tick,
    output logic [8:0] wall_addr,
    input  logic       wall_q,
    output logic [9:0] pac_x,
    output logic [8:0] pac_y,
    output logic [1:0] dir,
    output logic       moving
);

    state_t     state_q, state_d;
    logic [9:0] pac_x_q, pac_x_d;
    logic [8:0] pac_y_q, pac_y_d;
    dir_t       dir_q, dir_d;
    logic       moving_q, moving_d;
    logic       pend_valid_q, pend_valid_d;
    dir_t       pend_dir_q, pend_dir_d;
    logic [8:0] wall_addr_q, wall_addr_d;
    logic       oob_q, oob_d;

    logic       evt_valid;
    logic [1:0] evt_dir;
    logic       aligned;
    logic       blocked;
    nbr_t       nbr_p, nbr_c;

    pac_key_dec u_key_dec (
        .clk       (clk),
        .rst       (rst),
        .key_code  (key_code),
        .key_ready (key_ready),
        .ps2_code  (ps2_code),
        .ps2_ready (ps2_ready),
        .evt_valid (evt_valid),
        .evt_dir   (evt_dir)
    );

    assign aligned = (pac_x_q[4:0] == 5'd0) && (pac_y_q[4:0] == 5'd0);
    // Off-map neighbours never touch the ROM; they read as walls.
    assign blocked = oob_q | wall_q;
    assign nbr_p   = nbr_tile(pac_x_q, pac_y_q, pend_dir_q);
    assign nbr_c   = nbr_tile(pac_x_q, pac_y_q, dir_q);

    // State and datapath registers; reset aborts any update in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pac_x_q      <= START_X;
            pac_y_q      <= START_Y;
            dir_q        <= DIR_RIGHT;
            moving_q     <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_dir_q   <= DIR_LEFT;
            wall_addr_q  <= 9'd0;
            oob_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pac_x_q      <= pac_x_d;
            pac_y_q      <= pac_y_d;
            dir_q        <= dir_d;
            moving_q     <= moving_d;
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
            wall_addr_q  <= wall_addr_d;
            oob_q        <= oob_d;
        end
    end

    // Next-state: ticks outside IDLE are dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    if (!aligned)         state_d = ST_STEP;
                    else if (pend_valid_q) state_d = ST_LOOK_P;
                    else                   state_d = ST_LOOK_C;
                end
            end
            ST_LOOK_P: state_d = ST_CHK_P;
            ST_CHK_P:  state_d = blocked ? ST_LOOK_C : ST_STEP;
            ST_LOOK_C: state_d = ST_CHK_C;
            ST_CHK_C:  state_d = blocked ? ST_IDLE : ST_STEP;
            ST_STEP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath: ROM address on LOOK entry, heading/position updates, request latch
    always_comb begin
        pac_x_d      = pac_x_q;
        pac_y_d      = pac_y_q;
        dir_d        = dir_q;
        moving_d     = moving_q;
        pend_valid_d = pend_valid_q;
        pend_dir_d   = pend_dir_q;
        wall_addr_d  = wall_addr_q;
        oob_d        = oob_q;

        // Address is registered when entering LOOK so the ROM sees it during LOOK.
        if (state_d == ST_LOOK_P) begin
            oob_d = nbr_p.oob;
            if (!nbr_p.oob) wall_addr_d = nbr_p.addr;
        end else if (state_d == ST_LOOK_C) begin
            oob_d = nbr_c.oob;
            if (!nbr_c.oob) wall_addr_d = nbr_c.addr;
        end

        case (state_q)
            ST_CHK_P: begin
                if (!blocked) begin
                    dir_d        = pend_dir_q;
                    pend_valid_d = 1'b0;
                end
            end
            ST_CHK_C: begin
                if (blocked) moving_d = 1'b0;
            end
            ST_STEP: begin
                moving_d = 1'b1;
                case (dir_q)
                    DIR_LEFT:  pac_x_d = pac_x_q - 10'(STEP);
                    DIR_RIGHT: pac_x_d = pac_x_q + 10'(STEP);
                    DIR_UP:    pac_y_d = pac_y_q - 9'(STEP);
                    default:   pac_y_d = pac_y_q + 9'(STEP);
                endcase
            end
            default: ;
        endcase

        // A new request always wins over the clear above.
        if (evt_valid) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = dir_t'(evt_dir);
        end
    end

    assign wall_addr = wall_addr_q;
    assign pac_x     = pac_x_q;
    assign pac_y     = pac_y_q;
    assign dir       = dir_q;
    assign moving    = moving_q;

endmodule

// File: doc/pac_motion.md
PAC_MOTION -- requirements
Module: pac_motion

Interface
REQ-001 clk  in  1  system clock, 100 MHz.
REQ-002 rst  in  1  synchronous, active-low reset.
REQ-003 key_code  in  5  keypad code; valid while key_ready=1.
REQ-004 key_ready  in  1  keypad level flag; a rising edge is one event.
REQ-005 ps2_code  in  8  PS/2 set-2 scan code; valid while ps2_ready=1.
REQ-006 ps2_ready  in  1  PS/2 level flag; a rising edge is one event.
REQ-007 tick  in  1  one-clk frame strobe; starts one motion update.
REQ-008 wall_addr  out  9  maze tile index, row*20+col, for a synchronous map ROM with 1-clk latency.
REQ-009 wall_q  in  1  ROM data: 1 = wall.
REQ-010 pac_x  out  10  sprite left edge, pixels.
REQ-011 pac_y  out  9  sprite top edge, pixels.
REQ-012 dir  out  2  current heading: 0 = left, 1 = right, 2 = up, 3 = down.
REQ-013 moving  out  1  1 = the last update advanced the sprite.

Function
REQ-014 Event decode:
- Keypad rising edge: 0x0C left, 0x0E right, 0x09 up, 0x11 down.
- PS/2 rising edge: 0x1C left (A), 0x23 right (D), 0x1D up (W), 0x1B down (S).
- Other codes are ignored.
REQ-015 A PS/2 code 0xF0 arms a skip flag; the next PS/2 event is discarded and clears the flag.
REQ-016 A decoded event writes pend_dir and sets pend_valid. A later event overwrites it (last wins).
REQ-017 If keypad and PS/2 events arrive in the same clk, the keypad event wins.
REQ-018 Geometry: 32x32 sprite, 32-px tiles, 20x15 map, STEP = 2 px per update.
- Aligned means pac_x[4:0]=0 and pac_y[4:0]=0.
REQ-019 FSM states: IDLE, LOOK_P, CHK_P, LOOK_C, CHK_C, STEP.
- Updates start only from IDLE.
- A tick arriving in any other state is dropped.
REQ-020 IDLE + tick:
- Not aligned -> STEP, keeping the current dir.
- Aligned and pend_valid -> LOOK_P.
- Aligned and no pending request -> LOOK_C.
REQ-021 LOOK_P / LOOK_C:
- Drive wall_addr with the neighbour tile in pend_dir (LOOK_P) or dir (LOOK_C).
- Go to CHK_P / CHK_C on the next clk, where wall_q is sampled.
REQ-022 A neighbour tile outside the map (col<0, col>19, row<0, row>14) counts as a wall.
- No ROM access is made for it.
- The FSM still passes through the CHK state.
REQ-023 CHK_P:
- Free -> dir <= pend_dir, clear pend_valid, go to STEP.
- Wall -> LOOK_C; pend_valid stays set.
REQ-024 CHK_C:
- Free -> STEP.
- Wall -> moving <= 0, go to IDLE.
REQ-025 STEP:
- Add or subtract 2 px on the axis of dir.
- moving <= 1, go to IDLE.
- Total latency from tick to a position change is 1 clk (unaligned) or 3-5 clks (aligned).
REQ-026 Positions always stay within 0..608 (x) and 0..448 (y); the wall rule guarantees this, so no wrap-around occurs.
REQ-027 wall_addr holds its last value outside the LOOK states.
REQ-028 Events arriving during any FSM state are latched and take effect at the next aligned update.

Reset
REQ-029 While rst=0 at a clk edge:
- pac_x=32, pac_y=32, dir=1 (right), moving=0.
- pend_valid=0, skip flag=0, FSM=IDLE, wall_addr=0.
- Ready-edge history registers <= 1, so a key already held through reset does not produce an event.
REQ-030 Reset asserted mid-update aborts the update; no partial step is applied.

Structure
REQ-031 Shared package pac_pkg holds:
- the direction encoding;
- the keypad and PS/2 code constants;
- the STEP, TILE, MAP_W=20 and MAP_H=15 constants;
- the start position constants.
REQ-032 Sub-module pac_key_dec holds edge detection, break-code skip, priority and the code-to-direction mapping. It outputs a 1-clk evt_valid and evt_dir.

Verification
REQ-033 Reset, then one tick with an all-free map -> LOOK_C then STEP; pac_x=34, pac_y=32, moving=1.
REQ-034 At (32,32), press keypad 0x11 (down), map free, tick -> wall_addr=41; dir=3; pac_y=34; pend_valid=0.
REQ-035 At (32,32), press down with tile 41 a wall and tile 22 free, tick -> dir stays 1; pac_x=34; pend_valid stays 1.
REQ-036 At (0,32) heading left, tick -> no ROM access; moving=0; pac_x=0.
REQ-037 PS/2 sequence 0xF0, 0x1C, then 0x23 -> the A break is skipped; pend_dir=1 (right).
REQ-038 Keypad 0x0C and PS/2 0x23 in the same clk -> pend_dir=0; assert rst during CHK_P -> position returns to (32,32) the next clk.
